put_fsm: RTL and testbench

Write-side sub-FSM of the cache controller, counterpart to the lookup/read sub-FSM. On `enter` it resolves a PUT request to a target slot in one of three ways: overwrite on key hit, take a free slot, or evict the victim slot. It then drives a single-write handshake to the entry memory with a bounded wait and reports completion and success to the top-level controller. The top controller owns arbitration and only steps this block while `en` is high.

---
 rtl/put_fsm.sv | 127 ++++++++++++
 tb/tb_put_fsm.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/put_fsm.sv
// put_fsm: write-side sub-FSM of the cache controller.
// A PUT resolves its target slot (key hit, then free slot, then eviction
// victim), issues one write to the entry memory with a bounded wait for
// wr_ack, then pulses done/rdy_out with op_succ.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   en                           step enable from the top controller
//   enter                        start (or restart) a PUT, any state
//   hit, hit_idx                 key hit and its slot
//   free_valid, free_idx         lowest empty slot, if any
//   victim_idx                   replacement victim
//   wr_ack                       memory accepted the write
//   wr_req, wr_idx               write request / target slot
//   evict                        victim entry at wr_idx is being discarded
//   done, rdy_out, op_succ       completion pulse, result valid, success
//   busy                         not idle (ungated by en)
module put_fsm #(
  parameter int NUM_ENTRIES = 8,
  parameter int IDX_W       = $clog2(NUM_ENTRIES),
  parameter int MAX_WAIT    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             enter,
  input  logic             hit,
  input  logic [IDX_W-1:0] hit_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic [IDX_W-1:0] victim_idx,
  input  logic             wr_ack,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_idx,
  output logic             evict,
  output logic             done,
  output logic             rdy_out,
  output logic             op_succ,
  output logic             busy
);

  localparam int CNT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    PUT_ST_IDLE,
    PUT_ST_LOOKUP,
    PUT_ST_EVICT,
    PUT_ST_WRITE,
    PUT_ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             succ_q, succ_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PUT_ST_IDLE;
      tgt_q   <= '0;
      cnt_q   <= '0;
      succ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      succ_q  <= succ_d;
    end
  end

  // enter overrides everything (including en=0) and silently drops any
  // operation in flight; otherwise nothing moves unless en is high.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    succ_d  = succ_q;
    if (enter) begin
      state_d = PUT_ST_LOOKUP;
      cnt_d   = '0;
      succ_d  = 1'b0;
    end else if (en) begin
      unique case (state_q)
        PUT_ST_LOOKUP: begin
          if (hit) begin
            tgt_d   = hit_idx;
            state_d = PUT_ST_WRITE;
          end else if (free_valid) begin
            tgt_d   = free_idx;
            state_d = PUT_ST_WRITE;
          end else begin
            tgt_d   = victim_idx;
            state_d = PUT_ST_EVICT;
          end
        end
        PUT_ST_EVICT: state_d = PUT_ST_WRITE;
        PUT_ST_WRITE: begin
          // ack is checked first so an ack in the last wait cycle succeeds
          if (wr_ack) begin
            succ_d  = 1'b1;
            state_d = PUT_ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            succ_d  = 1'b0;
            state_d = PUT_ST_DONE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PUT_ST_DONE: state_d = PUT_ST_IDLE;
        default:     state_d = PUT_ST_IDLE;
      endcase
    end
  end

  // Moore decode; handshake outputs are gated by en, busy/wr_idx are not.
  always_comb begin
    wr_req  = en && (state_q == PUT_ST_WRITE);
    evict   = en && (state_q == PUT_ST_EVICT);
    done    = en && (state_q == PUT_ST_DONE);
    rdy_out = done;
    op_succ = done && succ_q;
    busy    = (state_q != PUT_ST_IDLE);
    wr_idx  = ((state_q == PUT_ST_EVICT) || (state_q == PUT_ST_WRITE)) ? tgt_q : '0;
  end

endmodule

// File: tb/tb_put_fsm.sv
// Randomized + directed bench for put_fsm. Stimulus computes, from the
// slot-selection priority and the ack/timeout rules, what each PUT should
// produce and queues it; a negedge monitor collects what the DUT actually
// did per operation and compares on every done pulse.
module tb_put_fsm;
  localparam int NUM_ENTRIES = 8;
  localparam int IDX_W       = 3;
  localparam int MAX_WAIT    = 4;

  logic             clk = 1'b0;
  logic             rst_n, en, enter, hit, free_valid, wr_ack;
  logic [IDX_W-1:0] hit_idx, free_idx, victim_idx;
  logic             wr_req, evict, done, rdy_out, op_succ, busy;
  logic [IDX_W-1:0] wr_idx;

  put_fsm #(.NUM_ENTRIES(NUM_ENTRIES), .IDX_W(IDX_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .enter(enter), .hit(hit),
    .hit_idx(hit_idx), .free_valid(free_valid), .free_idx(free_idx),
    .victim_idx(victim_idx), .wr_ack(wr_ack), .wr_req(wr_req),
    .wr_idx(wr_idx), .evict(evict), .done(done), .rdy_out(rdy_out),
    .op_succ(op_succ), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ev;
    int idx;
    bit succ;
    int nwr;
    int lat;
  } exp_t;
  exp_t sbq[$];

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Transaction-level model state: enabled steps left before idle.
  int rem = 0;
  int total_pending = 0;
  bit exp_busy = 1'b0;

  task automatic drive_cycle(input bit en_v, input bit ent_v, input bit ack_v);
    en = en_v; enter = ent_v; wr_ack = ack_v;
    @(posedge clk);
    if (ent_v) rem = total_pending;
    else if (en_v && rem > 0) rem--;
    #1;
    exp_busy = (rem > 0);
  endtask

  // kind: 0 hit, 1 free slot, 2 evict. idx<0 picks a random slot.
  // ack_k: 1-based enabled WRITE cycle carrying ack; outside 1..MAX_WAIT = none.
  // en_mode: 0 always on, 1 random, 2 three-cycle stall at first WRITE.
  // abort: 0 none, 1 stop in WRITE, 2 stop in EVICT (caller takes over).
  task automatic run_put(input int kind, input int idx, input int ack_k,
                         input int en_mode, input int abort);
    int tidx, nwr, total, p, w, stall;
    bit ev, succ, is_wr, en_v, ack_v;
    exp_t e;
    tidx = (idx < 0) ? int'($urandom_range(0, NUM_ENTRIES-1)) : idx;
    hit        = (kind == 0);
    hit_idx    = (kind == 0) ? IDX_W'(tidx) : IDX_W'($urandom_range(0, NUM_ENTRIES-1));
    free_valid = (kind == 1) ? 1'b1 : (kind == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    free_idx   = (kind == 1) ? IDX_W'(tidx) : IDX_W'($urandom_range(0, NUM_ENTRIES-1));
    victim_idx = (kind == 2) ? IDX_W'(tidx) : IDX_W'($urandom_range(0, NUM_ENTRIES-1));
    // reference: priority hit > free > victim
    ev   = !hit && !free_valid;
    e.idx = hit ? int'(hit_idx) : free_valid ? int'(free_idx) : int'(victim_idx);
    succ = (ack_k >= 1 && ack_k <= MAX_WAIT);
    nwr  = succ ? ack_k : MAX_WAIT;
    total = 2 + int'(ev) + nwr;
    e.ev = ev; e.succ = succ; e.nwr = nwr; e.lat = total;
    if (abort == 0) sbq.push_back(e);
    total_pending = total;
    drive_cycle(en_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    stall = 0;
    while (rem > 0) begin
      p = total - rem;
      w = p - int'(ev);
      is_wr = (p > int'(ev)) && (w <= nwr);
      if (abort == 1 && is_wr) return;
      if (abort == 2 && ev && p == 1) return;
      if (en_mode == 0) en_v = 1'b1;
      else if (en_mode == 1) en_v = ($urandom_range(0, 3) != 0);
      else if (is_wr && w == 1 && stall < 3) begin en_v = 1'b0; stall++; end
      else en_v = 1'b1;
      if (en_v && is_wr) ack_v = (w == ack_k);
      else ack_v = 1'($urandom_range(0, 1));
      drive_cycle(en_v, 1'b0, ack_v);
    end
    repeat (2) drive_cycle(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Monitor: accumulates per-operation observations, checks on done.
  int m_lat, m_nwr, m_nev, m_idx;
  bit m_seen, m_unstable, m_both;

  task automatic m_clear();
    m_lat = 0; m_nwr = 0; m_nev = 0; m_idx = 0;
    m_seen = 0; m_unstable = 0; m_both = 0;
  endtask

  task automatic m_track();
    if (!m_seen) begin m_seen = 1; m_idx = int'(wr_idx); end
    else if (int'(wr_idx) != m_idx) m_unstable = 1;
  endtask

  initial begin
    exp_t e;
    m_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) m_clear();
      else begin
        chk("busy", int'(busy), int'(exp_busy));
        if (!en) chk("gated_outputs", int'(wr_req | evict | done | rdy_out), 0);
        if (enter) m_clear();
        else begin
          if (en) m_lat++;
          if (wr_req) begin m_nwr++; m_track(); end
          if (evict) begin m_nev++; m_track(); end
          if (wr_req && evict) m_both = 1;
          if (done || rdy_out) chk("rdy_eq_done", int'(rdy_out), int'(done));
          if (done) begin
            if (sbq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
              e = sbq.pop_front();
              chk("op_succ", int'(op_succ), int'(e.succ));
              chk("evict_cnt", m_nev, int'(e.ev));
              chk("wr_req_cycles", m_nwr, e.nwr);
              chk("wr_idx", m_idx, e.idx);
              chk("wr_idx_stable", int'(m_unstable), 0);
              chk("evict_wr_overlap", int'(m_both), 0);
              chk("latency", m_lat, e.lat);
              chk("wr_idx_done", int'(wr_idx), 0);
            end
            m_clear();
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; enter = 1'b0; wr_ack = 1'b1;
    hit = 1'b1; free_valid = 1'b1;
    hit_idx = '1; free_idx = '1; victim_idx = '1;
    #3;
    chk("rst_wr_req", int'(wr_req), 0);
    chk("rst_evict", int'(evict), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdy", int'(rdy_out), 0);
    chk("rst_succ", int'(op_succ), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_idx", int'(wr_idx), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; wr_ack = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b1);

    run_put(0, 5, 1, 0, 0);               // hit, immediate ack
    run_put(1, 2, 3, 0, 0);               // free slot, ack on 3rd WRITE
    run_put(2, 7, 1, 0, 0);               // eviction, immediate ack
    run_put(1, -1, 0, 0, 0);              // timeout
    run_put(0, -1, MAX_WAIT, 0, 0);       // ack in final wait cycle
    run_put(1, 3, 2, 2, 0);               // en stall during WRITE
    run_put(0, 4, 1, 0, 1);               // aborted in WRITE ...
    run_put(2, 6, 1, 0, 0);               // ... by this enter

    run_put(2, 7, 1, 0, 2);               // stop in EVICT, then reset
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_evict", int'(evict), 0);
    chk("rst_mid_wr_idx", int'(wr_idx), 0);
    rem = 0; exp_busy = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(1'b1, 1'b0, 1'b1);
    chk("post_rst_busy", int'(busy), 0);

    repeat (80)
      run_put(int'($urandom_range(0, 2)), -1, int'($urandom_range(0, MAX_WAIT+1)),
              1, ($urandom_range(0, 9) == 0) ? 1 : 0);
    run_put(1, -1, 1, 0, 0);
    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
